// File: rtl/aq_gemac_tx_buff.sv
// aq_gemac_tx_buff: transmit frame buffer, host 32-bit words in, MAC byte stream out
// Ports:
//   MAC_CLK, RST          single clock, synchronous active-high reset
//   BUFF_WE/START/END     host word strobe with first/last-word qualifiers
//   BUFF_DATA, BUFF_LENGTH frame word (byte 0 in [7:0]) and byte length sampled with END
//   BUFF_ABORT            discard frame in progress (only with AQ_GEMAC_TX_ABORT_EN)
//   BUFF_FULL, BUFF_DROP  no space / length queue full; one-cycle discard pulse
//   MAC_VALID/RE/DATA     byte handshake towards the MAC transmitter
//   MAC_START, MAC_END    first / last byte qualifiers
//   FRAME_COUNT           committed frames not yet fully read
// Optional feature macro: AQ_GEMAC_TX_ABORT_EN enables BUFF_ABORT.
module aq_gemac_tx_buff #(
    parameter int EMAC_TX_DEPTH  = 10,
    parameter int EMAC_TX_FRAMES = 2
) (
    input  logic                      MAC_CLK,
    input  logic                      RST,
    input  logic                      BUFF_WE,
    input  logic                      BUFF_START,
    input  logic                      BUFF_END,
    input  logic [31:0]               BUFF_DATA,
    input  logic [15:0]               BUFF_LENGTH,
    input  logic                      BUFF_ABORT,
    output logic                      BUFF_FULL,
    output logic                      BUFF_DROP,
    output logic                      MAC_VALID,
    input  logic                      MAC_RE,
    output logic [7:0]                MAC_DATA,
    output logic                      MAC_START,
    output logic                      MAC_END,
    output logic [EMAC_TX_FRAMES:0]   FRAME_COUNT
);
    localparam int D = EMAC_TX_DEPTH;
    localparam int F = EMAC_TX_FRAMES;
    localparam logic [D:0] WORDS = {1'b1, {D{1'b0}}};
    localparam logic [F:0] SLOTS = {1'b1, {F{1'b0}}};
    localparam logic [D:0] W_ONE = 1;
    localparam logic [F:0] Q_ONE = 1;

    typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DATA} r_state_t;

    logic [31:0] mem [0:(1<<D)-1];
    logic [15:0] lq  [0:(1<<F)-1];
    logic [D:0]  wr, wr_base, rd, ra, wa;
    logic [F:0]  q_wr, q_rd;
    logic [D+1:0] nw;
    logic        active, ovf, abort, take, fits, ovf_n, ok;
    logic [31:0] rdata, word;
    logic [15:0] bcnt, len;
    logic [1:0]  bsel, nb;
    logic        ph, re, acc;
    r_state_t    state, state_n;

    assign FRAME_COUNT = q_wr - q_rd;

`ifdef AQ_GEMAC_TX_ABORT_EN
    assign abort = BUFF_ABORT;
`else
    logic unused_abort;
    assign unused_abort = BUFF_ABORT;
    assign abort = 1'b0;
`endif

    // Write side: START restarts at the last committed end; the frame is only
    // published to the reader when its length is consistent and nothing overflowed.
    always_comb begin
        take  = BUFF_WE && (BUFF_START || active) && !abort;
        wa    = BUFF_START ? wr_base : wr;
        fits  = (wa - rd) != WORDS;
        ovf_n = (!BUFF_START && ovf) || !fits;
        nw    = {1'b0, wa - wr_base} + {{(D+1){1'b0}}, fits};
        ok    = !ovf_n && BUFF_LENGTH != 16'd0 && 18'(BUFF_LENGTH) <= 18'({nw, 2'b00})
                && FRAME_COUNT != SLOTS;
    end

    always_ff @(posedge MAC_CLK) begin
        if (take && fits)
            mem[wa[D-1:0]] <= BUFF_DATA;
        if (take && BUFF_END && ok)
            lq[q_wr[F-1:0]] <= BUFF_LENGTH;
        if (re)
            rdata <= mem[ra[D-1:0]];
    end

    always_ff @(posedge MAC_CLK) begin
        if (RST) begin
            wr        <= '0;
            wr_base   <= '0;
            q_wr      <= '0;
            active    <= 1'b0;
            ovf       <= 1'b0;
            BUFF_DROP <= 1'b0;
            BUFF_FULL <= 1'b0;
        end else begin
            BUFF_DROP <= 1'b0;
            BUFF_FULL <= (wr - rd) == WORDS || FRAME_COUNT == SLOTS;
            if (abort) begin
                wr        <= wr_base;
                active    <= 1'b0;
                ovf       <= 1'b0;
                BUFF_DROP <= 1'b1;
            end else if (take) begin
                if (BUFF_END) begin
                    active <= 1'b0;
                    ovf    <= 1'b0;
                    if (ok) begin
                        wr      <= wa + W_ONE;
                        wr_base <= wa + W_ONE;
                        q_wr    <= q_wr + Q_ONE;
                    end else begin
                        wr        <= wr_base;
                        BUFF_DROP <= 1'b1;
                    end
                end else begin
                    wr     <= fits ? wa + W_ONE : wa;
                    active <= 1'b1;
                    ovf    <= ovf_n;
                end
            end
        end
    end

    // Read side: two-word prefetch keeps the next word in rdata so a word
    // boundary never costs a cycle.
    always_comb begin
        state_n = state;
        re      = 1'b0;
        acc     = MAC_VALID && MAC_RE;
        nb      = bsel + 2'd1;
        case (state)
            R_IDLE:  state_n = FRAME_COUNT != '0 ? R_FETCH : R_IDLE;
            R_FETCH: begin
                re      = 1'b1;
                state_n = ph ? R_DATA : R_FETCH;
            end
            R_DATA: begin
                re      = acc && !MAC_END && bsel == 2'd3;
                state_n = acc && MAC_END ? R_IDLE : R_DATA;
            end
            default: state_n = R_IDLE;
        endcase
    end

    always_ff @(posedge MAC_CLK) begin
        if (RST)
            state <= R_IDLE;
        else
            state <= state_n;
    end

    always_ff @(posedge MAC_CLK) begin
        if (RST) begin
            ra        <= '0;
            rd        <= '0;
            q_rd      <= '0;
            ph        <= 1'b0;
            bcnt      <= '0;
            len       <= '0;
            bsel      <= '0;
            word      <= '0;
            MAC_VALID <= 1'b0;
            MAC_DATA  <= '0;
            MAC_START <= 1'b0;
            MAC_END   <= 1'b0;
        end else begin
            if (re)
                ra <= ra + W_ONE;
            case (state)
                R_IDLE: begin
                    ra   <= rd;
                    ph   <= 1'b0;
                    bcnt <= lq[q_rd[F-1:0]];
                    len  <= lq[q_rd[F-1:0]];
                end
                R_FETCH: begin
                    ph <= 1'b1;
                    if (ph) begin
                        word      <= rdata;
                        bsel      <= 2'd0;
                        MAC_VALID <= 1'b1;
                        MAC_DATA  <= rdata[7:0];
                        MAC_START <= 1'b1;
                        MAC_END   <= bcnt == 16'd1;
                    end
                end
                R_DATA: begin
                    if (acc) begin
                        if (MAC_END) begin
                            MAC_VALID <= 1'b0;
                            MAC_START <= 1'b0;
                            MAC_END   <= 1'b0;
                            rd        <= rd + (D+1)'((17'(len) + 17'd3) >> 2);
                            q_rd      <= q_rd + Q_ONE;
                        end else begin
                            bcnt      <= bcnt - 16'd1;
                            bsel      <= nb;
                            MAC_START <= 1'b0;
                            MAC_END   <= bcnt == 16'd2;
                            if (bsel == 2'd3) begin
                                word     <= rdata;
                                MAC_DATA <= rdata[7:0];
                            end else begin
                                MAC_DATA <= word[{nb, 3'b000} +: 8];
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_aq_gemac_tx_buff.sv
// tb_aq_gemac_tx_buff: directed scoreboard bench for the transmit frame buffer
module tb_aq_gemac_tx_buff;
    logic        clk = 1'b0, rst = 1'b1, we = 1'b0, st = 1'b0, en = 1'b0, ab = 1'b0, re = 1'b0;
    logic [31:0] data = '0;
    logic [15:0] len = '0;
    logic        full, drop, valid, mstart, mend;
    logic [7:0]  mdata;
    logic [2:0]  fcnt;
    int          tests = 0, fails = 0;
    logic [9:0]  sb[$];

    aq_gemac_tx_buff dut (
        .MAC_CLK(clk), .RST(rst), .BUFF_WE(we), .BUFF_START(st), .BUFF_END(en),
        .BUFF_DATA(data), .BUFF_LENGTH(len), .BUFF_ABORT(ab), .BUFF_FULL(full),
        .BUFF_DROP(drop), .MAC_VALID(valid), .MAC_RE(re), .MAC_DATA(mdata),
        .MAC_START(mstart), .MAC_END(mend), .FRAME_COUNT(fcnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic s, input logic e, input logic [31:0] d, input logic [15:0] l);
        we = 1'b1; st = s; en = e; data = d; len = l;
        tick();
        we = 1'b0; st = 1'b0; en = 1'b0;
    endtask

    task automatic send(input int nw, input int l, input logic ok);
        logic [31:0] w[$];
        logic [31:0] x;
        for (int i = 0; i < nw; i++) w.push_back($urandom);
        if (ok)
            for (int k = 0; k < l; k++) begin
                x = w[k/4];
                sb.push_back({x[8*(k%4) +: 8], k == 0, k == l-1});
            end
        for (int i = 0; i < nw; i++) put(i == 0, i == nw-1, w[i], 16'(l));
        check("drop", drop, !ok);
    endtask

    task automatic drain(input int budget, input logic tog);
        int n = 0;
        while ((sb.size() != 0 || fcnt != 0 || valid) && n < budget) begin
            if (tog) re = ~re;
            tick();
            n++;
        end
        re = 1'b1;
        check("drain_sb", sb.size(), 0);
        check("drain_cnt", fcnt, 0);
    endtask

    logic       hold = 1'b0, inf = 1'b0, ended = 1'b0;
    logic [9:0] hv, ex;
    always @(negedge clk) begin
        if (rst) begin
            hold = 1'b0; inf = 1'b0; ended = 1'b0;
        end else begin
            if (hold) check("stable", {valid, mdata, mstart, mend}, {1'b1, hv});
            if (ended) check("gap", valid, 0);
            if (inf && re) check("bubble", valid, 1);
            ended = 1'b0;
            if (valid && re) begin
                if (sb.size() == 0)
                    check("sb_depth", sb.size(), 1);
                else begin
                    ex = sb.pop_front();
                    check("byte", {mdata, mstart, mend}, ex);
                end
                ended = mend;
                inf = !mend;
            end
            hold = valid && !re;
            hv = {mdata, mstart, mend};
        end
    end

    initial begin
        repeat (2) tick();
        check("rst_full", full, 0);
        check("rst_drop", drop, 0);
        check("rst_valid", valid, 0);
        check("rst_data", mdata, 0);
        check("rst_start", mstart, 0);
        check("rst_end", mend, 0);
        check("rst_cnt", fcnt, 0);
        rst = 1'b0;
        re = 1'b1;
        tick();
        send(16, 64, 1);
        check("cnt_commit", fcnt, 1);
        tick();
        check("lat1", valid, 0);
        tick();
        check("lat2", valid, 0);
        tick();
        check("lat3", {valid, mstart}, 2'b11);
        drain(200, 0);
        send(16, 61, 1);
        drain(200, 0);
        send(16, 0, 0);
        check("len0_cnt", fcnt, 0);
        send(16, 65, 0);
        check("len65_cnt", fcnt, 0);
        repeat (5) tick();
        check("drop_novalid", valid, 0);
        put(1, 0, $urandom, 0);
        for (int i = 1; i < 1024; i++) put(0, 0, $urandom, 0);
        check("full_lag", full, 0);
        tick();
        check("full", full, 1);
        put(0, 0, $urandom, 0);
        put(0, 1, $urandom, 16'd4);
        check("ovf_drop", drop, 1);
        check("ovf_cnt", fcnt, 0);
        tick();
        check("full_clear", full, 0);
        put(1, 0, $urandom, 0);
        put(0, 0, $urandom, 0);
        put(0, 0, $urandom, 0);
        send(2, 8, 1);
        drain(200, 0);
        put(0, 0, $urandom, 0);
        put(0, 1, $urandom, 16'd4);
        check("orphan_drop", drop, 0);
        check("orphan_cnt", fcnt, 0);
        send(1000, 4000, 1);
        drain(5000, 0);
        re = 1'b0;
        for (int i = 0; i < 4; i++) send(1, 1, 1);
        check("q_cnt4", fcnt, 4);
        tick();
        check("q_full", full, 1);
        send(1, 1, 0);
        drain(200, 1);
        tick();
        check("q_full_clear", full, 0);
        re = 1'b0;
        send(2, 8, 1);
        put(1, 0, $urandom, 0);
        repeat (3) tick();
        rst = 1'b1;
        sb.delete();
        tick();
        check("mid_rst_valid", valid, 0);
        check("mid_rst_cnt", fcnt, 0);
        rst = 1'b0;
        re = 1'b1;
`ifdef AQ_GEMAC_TX_ABORT_EN
        for (int i = 0; i < 5; i++) put(i == 0, 0, $urandom, 0);
        ab = 1'b1;
        tick();
        ab = 1'b0;
        check("abort_drop", drop, 1);
        send(3, 12, 1);
        drain(200, 0);
`else
        sb.push_back(10'h000);
        sb.delete();
        begin
            logic [31:0] w0, w1, w2, x;
            w0 = $urandom; w1 = $urandom; w2 = $urandom;
            for (int k = 0; k < 12; k++) begin
                x = k < 4 ? w0 : k < 8 ? w1 : w2;
                sb.push_back({x[8*(k%4) +: 8], k == 0, k == 11});
            end
            put(1, 0, w0, 0);
            put(0, 0, w1, 0);
            ab = 1'b1;
            tick();
            ab = 1'b0;
            check("abort_ignored", drop, 0);
            put(0, 1, w2, 16'd12);
            check("abort_commit", fcnt, 1);
        end
        drain(200, 0);
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/aq_gemac_tx_buff.md
# aq_gemac_tx_buff

Transmit-side frame buffer of the Giga Ethernet MAC: accepts whole frames as 32-bit words from the host/DMA side and replays them as a byte stream into the MAC transmitter. A frame becomes visible to the MAC only after it has been committed with its byte length, so the MAC never starts a partial frame. Single clock domain; sits between the host bus adapter and the MAC TX engine.

## Interface
- EMAC_TX_DEPTH, 10, log2 of data memory depth in 32-bit words
- EMAC_TX_FRAMES, 2, log2 of committed-frame (length) queue depth
- MAC_CLK  in  1  the only clock; all logic on its rising edge
- RST  in  1  reset: one clock; reset is synchronous and active-high
- BUFF_WE  in  1  host word write strobe
- BUFF_START  in  1  with BUFF_WE: first word of a frame
- BUFF_END  in  1  with BUFF_WE: last word; commits frame
- BUFF_DATA  in  32  frame word, byte 0 in [7:0]
- BUFF_LENGTH  in  16  frame byte length, sampled with BUFF_END
- BUFF_ABORT  in  1  discard frame being written (see Configuration)
- BUFF_FULL  out  1  no free word or length queue full
- BUFF_DROP  out  1  one-cycle pulse: frame discarded
- MAC_VALID  out  1  MAC_DATA holds a valid byte
- MAC_RE  in  1  MAC accepts byte this cycle (MAC_VALID && MAC_RE)
- MAC_DATA  out  8  transmit byte
- MAC_START  out  1  qualifies first byte of frame
- MAC_END  out  1  qualifies last byte of frame
- FRAME_COUNT  out  EMAC_TX_FRAMES+1  committed frames not yet fully read

## Operation
- Word pointers EMAC_TX_DEPTH+1 bits (wrap bit). Pointers: wr (current write), wr_base (last committed end), rd (MAC side). Free words = 2**EMAC_TX_DEPTH − (wr − rd).
- Write: BUFF_WE && BUFF_START sets wr to wr_base then stores word; BUFF_START mid-frame silently restarts at wr_base (no BUFF_DROP).
- BUFF_WE && BUFF_END: word stored; if BUFF_LENGTH in 1..4×words_written and no overflow, push length to queue, wr_base ← wr+1; else wr ← wr_base, BUFF_DROP pulse.
- BUFF_WE while no free word: word not stored, frame flagged overflow; discarded at BUFF_END.
- BUFF_WE without active frame (no START seen): ignored.
- Read FSM: R_IDLE → R_FETCH when FRAME_COUNT≠0 (registered memory read, prefetch 2 words) → R_DATA → R_IDLE after last byte accepted.
- R_DATA: bytes emitted little-endian from word; byte counter from queued length; MAC_START on byte 0, MAC_END when counter = 1 (both on single-byte frame).
- End of frame: rd ← frame start + ceil(len/4), pop length queue.
- Arithmetic: byte counter 16 bits, word count ceil(len/4) computed as (len+3)>>2 in 17 bits.

## Timing
- Reset values: BUFF_FULL 0, BUFF_DROP 0, MAC_VALID 0, MAC_DATA 0, MAC_START 0, MAC_END 0, FRAME_COUNT 0; FSM R_IDLE; all pointers 0; queue empty.
- Commit → FRAME_COUNT increments next cycle; MAC_VALID first asserted 3 cycles after commit edge.
- With MAC_RE held high, one byte per cycle, no bubbles inside a frame, including word boundaries and wrap of the memory address.
- MAC_VALID held, MAC_DATA stable while MAC_RE low.
- Back-to-back frames: at least 1 idle cycle (MAC_VALID low) between MAC_END and next MAC_START.
- Space freed (rd update, FRAME_COUNT decrement) the cycle after MAC_END accepted; BUFF_FULL recomputed registered, deasserts the following cycle.
- Simultaneous commit and read completion: FRAME_COUNT unchanged.
- RST mid-frame on either side: everything returns to reset state next edge; partial frames lost.

## Configuration
- AQ_GEMAC_TX_ABORT_EN defined: BUFF_ABORT high rewinds wr to wr_base, clears active frame, pulses BUFF_DROP; abort same cycle as BUFF_END wins (no commit).
- Undefined: BUFF_ABORT ignored, no abort logic; port remains.

## Test plan
- Write 16 words, END with length 64 → MAC_START on byte 0x(word0[7:0]), 64 consecutive bytes with MAC_RE high, MAC_END on byte 64, FRAME_COUNT 1→0.
- Length 61 over 16 words → 61 bytes, last byte = word15[7:0], rd advances 16.
- Length 0, and length 65 over 16 words → BUFF_DROP pulse, FRAME_COUNT stays 0, no MAC_VALID.
- Fill 1024 words without END → BUFF_FULL high; further writes + END → BUFF_DROP, buffer empty again.
- Four 1-word frames committed (EMAC_TX_FRAMES=2) → BUFF_FULL; MAC_RE toggling 1/0 → data stable when low, 4 frames each START&END on single byte if length 1.
- With AQ_GEMAC_TX_ABORT_EN: write 5 words, ABORT, then 3-word frame length 12 → only 12 bytes transmitted, frame starts at address 0.
